prg_loader: RTL

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/prg_loader_pkg.sv | 18 +
 rtl/prg_fifo.sv | 62 ++++++
 rtl/prg_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prg_loader_pkg.sv
// Shared state encoding and fixed addresses for the PRG file loader.
package prg_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StDrain,
        StPtrLo,
        StPtrHi
    } state_e;

    // Zero-page pointer patched with the end-of-program address.
    localparam logic [15:0] PTR_LO_ADDR = 16'h002A;
    localparam logic [15:0] PTR_HI_ADDR = 16'h002B;
    localparam int unsigned HDR_BYTES   = 2;

endpackage

// File: rtl/prg_fifo.sv
// Synchronous FIFO for {addr, byte} entries; same-cycle push and pop allowed, even when full.
module prg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL_CNT) || do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/prg_loader.sv
// Streams a PRG file from data_io into PET memory through the DMA port, then
// patches the end-of-program pointer in zero page.
module prg_loader
    import prg_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] TOP_ADDR   = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        prg_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        dma_slot,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        busy,
    output logic        clipped,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

    state_e      state_q;
    logic        dl_q;
    logic [15:0] addr_q;
    logic        clipped_q;
    logic        overflow_q;

    logic          start;
    logic          data_wr;
    logic          in_range;
    logic          fifo_pop;
    logic          fifo_space;
    logic          fifo_push;
    logic          ptr_we;
    logic [23:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    always_comb begin
        start      = prg_download && !dl_q;
        data_wr    = (state_q == StData) && prg_download && ioctl_wr &&
                     (ioctl_addr >= 25'(HDR_BYTES));
        in_range   = addr_q < TOP_ADDR;
        // A new download flushes the queue, so nothing is popped on that cycle.
        fifo_pop   = !start && dma_slot && !fifo_empty &&
                     ((state_q == StData) || (state_q == StDrain));
        fifo_space = !fifo_full || fifo_pop;
        fifo_push  = !start && data_wr && in_range && fifo_space;
        ptr_we     = !start && dma_slot && ((state_q == StPtrLo) || (state_q == StPtrHi));
    end

    prg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (start),
        .push    (fifo_push),
        .wdata   ({addr_q, ioctl_dout}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            addr_q     <= '0;
            clipped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dl_q <= prg_download;
            if (start) begin
                state_q    <= StHdr;
                addr_q     <= '0;
                clipped_q  <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: ;
                    StHdr: begin
                        if (!prg_download) begin
                            state_q <= StIdle;
                        end else if (ioctl_wr && (ioctl_addr == 25'd0)) begin
                            addr_q[7:0] <= ioctl_dout;
                        end else if (ioctl_wr && (ioctl_addr == 25'd1)) begin
                            addr_q[15:8] <= ioctl_dout;
                            state_q      <= StData;
                        end
                    end
                    StData: begin
                        if (!prg_download) begin
                            state_q <= StDrain;
                        end else if (data_wr) begin
                            // Clipped bytes freeze the address; dropped bytes still advance it.
                            if (!in_range) begin
                                clipped_q <= 1'b1;
                            end else begin
                                addr_q <= addr_q + 16'd1;
                                if (!fifo_space) overflow_q <= 1'b1;
                            end
                        end
                    end
                    StDrain: if (fifo_empty) state_q <= StPtrLo;
                    StPtrLo: if (dma_slot) state_q <= StPtrHi;
                    StPtrHi: if (dma_slot) state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        dma_we   = 1'b0;
        dma_addr = '0;
        dma_din  = '0;
        if (fifo_pop) begin
            dma_we   = 1'b1;
            dma_addr = fifo_rdata[23:8];
            dma_din  = fifo_rdata[7:0];
        end else if (ptr_we) begin
            dma_we = 1'b1;
            if (state_q == StPtrLo) begin
                dma_addr = PTR_LO_ADDR;
                dma_din  = addr_q[7:0];
            end else begin
                dma_addr = PTR_HI_ADDR;
                dma_din  = addr_q[15:8];
            end
        end
    end

    assign ioctl_wait = fifo_count >= WAIT_LEVEL;
    assign busy       = state_q != StIdle;
    assign clipped    = clipped_q;
    assign overflow   = overflow_q;

endmodule
